// File: rtl/uart_tx_fifo.sv
// Transmit side of the debug UART: a 16-entry byte FIFO feeding an 8N1 serialiser.
// The serialiser is paced only by the shared 16x oversampling baud tick.
module uart_tx_fifo #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_s_tick,
    input  logic            i_wr,
    input  logic [DBIT-1:0] i_wr_data,
    output logic            o_full,
    output logic            o_empty,
    output logic            o_tx,
    output logic            o_tx_done_tick,
    output logic            o_busy
);

    localparam int DEPTH    = 2 ** FIFO_AW;
    localparam int CNT_W    = FIFO_AW + 1;
    localparam int TICK_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int BIT_W    = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e              state_q, state_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DBIT-1:0]     shreg_q, shreg_d;
    logic                tx_q, tx_d;
    logic                done_evt_q, done_evt_d;
    logic                done_q, done_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DBIT-1:0]     mem_q [DEPTH];

    logic full;
    logic empty;
    logic wr_en;
    logic pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_en = i_wr && !full;

    // Serialiser next-state logic; pop is only ever raised from IDLE with data present.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        done_evt_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shreg_d    = mem_q[rd_ptr_q];
                    tick_cnt_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (i_s_tick) begin
                    if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        shreg_d    = shreg_q >> 1;
                        if (bit_cnt_q == BIT_W'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            STOP: begin
                if (i_s_tick) begin
                    if (tick_cnt_q == TICK_W'(SB_TICK - 1)) begin
                        tick_cnt_d = '0;
                        done_evt_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line and the done pulse follow the current state one clock later, so the
    // done pulse lands exactly where the stop bit ends on o_tx.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_q[0];
            default: tx_d = 1'b1;
        endcase
        done_d = done_evt_q;
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            done_evt_q <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            done_evt_q <= done_evt_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the cleared count keeps stale entries unreadable.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    assign o_full         = full;
    assign o_empty        = empty;
    assign o_tx           = tx_q;
    assign o_tx_done_tick = done_q;
    assign o_busy         = (state_q != IDLE);

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit end of the debug UART link.
- The debugger pushes response bytes (pipeline latch dumps, register file, data memory words) into an internal FIFO.
- The block serialises each byte as an 8N1 frame on o_tx, timed by the shared 16x oversampling baud tick.
- It complements the receive path (rx_done_tick) and drives the top-level o_uart_tx and tx_done_tick.

Parameters:
- DBIT, 8: data bits per frame, sent LSB first.
- SB_TICK, 16: baud ticks spent in the stop bit (16 = 1 stop bit).
- OVERSAMPLE, 16: baud ticks per start or data bit.
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW = 16 entries.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst  input  1  synchronous, active-low reset.
- i_s_tick  input  1  baud tick; one-cycle pulse at OVERSAMPLE x baud rate.
- i_wr  input  1  write strobe from the debugger (uart_tx_start).
- i_wr_data  input  DBIT  byte to enqueue.
- o_full  output  1  FIFO full (uart_tx_full).
- o_empty  output  1  FIFO empty.
- o_tx  output  1  serial line, registered, idle high.
- o_tx_done_tick  output  1  one-cycle pulse at the end of every stop bit.
- o_busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - o_tx=1, o_empty=1, o_full=0, o_tx_done_tick=0, o_busy=0.
  - FSM enters IDLE. FIFO pointers and count are cleared. Tick counter and bit counter are cleared.
- Reset mid-frame aborts the frame. o_tx is 1 after that edge, and all queued bytes are discarded.
- FIFO:
  - Circular buffer with a registered count.
  - o_full = (count == depth); o_empty = (count == 0).
  - A write is accepted when i_wr=1 and o_full=0 at that edge. A write while o_full=1 is dropped silently, even if a pop occurs in the same cycle.
  - A pop is performed only by the FSM, and only when o_empty=0 at that edge.
  - Simultaneous accepted write and pop: count is unchanged and both pointers advance.
  - Pointers wrap modulo depth.
- FSM states: IDLE, START, DATA, STOP. The tick counter counts only i_s_tick pulses.
- IDLE:
  - o_tx=1.
  - If o_empty=0: pop the head byte into the shift register, clear the tick counter, go to START.
- START:
  - o_tx=0.
  - On the tick where the counter reaches OVERSAMPLE-1: clear the counter, clear the bit counter, go to DATA.
- DATA:
  - o_tx = shift register bit 0.
  - After OVERSAMPLE ticks: shift right by one and increment the bit counter.
  - When the bit counter reaches DBIT-1 on that boundary, go to STOP instead.
- STOP:
  - o_tx=1.
  - After SB_TICK ticks: pulse o_tx_done_tick for exactly one clock, return to IDLE.
- Frame length = (1 + DBIT)*OVERSAMPLE + SB_TICK ticks = 160 ticks at the defaults.
- Latency:
  - Write accepted at edge N into an empty FIFO with the FSM in IDLE: o_empty=0 after N.
  - The FSM pops at edge N+1.
  - o_tx=0 after edge N+2.
- Back-to-back frames: the IDLE state lasts exactly one clock between frames when the FIFO is non-empty. The done pulse and the following pop are in consecutive cycles.
- i_s_tick asserted while in IDLE has no effect. Bit timing depends only on tick count, never on raw clock count.
- Writes continue to be accepted during transmission.
- The byte being shifted is held in the shift register, not in the FIFO. A full FIFO plus one frame in flight gives 17 bytes outstanding.

Test Plan:
- Reset: hold i_rst=0 for 3 cycles with i_wr=1 -> o_tx=1, o_empty=1, o_full=0, o_busy=0, no frame starts after release.
- Single byte with i_s_tick every cycle: write 0xA5 -> o_tx=0 two edges later. Then each 16 cycles o_tx shows the bits 1,0,1,0,0,1,0,1, then 1 for 16 cycles. o_tx_done_tick pulses once, 160 cycles after the start bit begins.
- Tick spacing: i_s_tick every 4 clocks, write 0x3C -> every bit lasts 64 clocks, and the frame decodes to 0x3C.
- Full and overflow: with ticks off, write 0x00..0x10 (17 bytes) -> first byte popped into the shift register, 16 bytes queued, o_full=1. Writing 0x11 is dropped. With ticks on, exactly 17 frames are sent (0x00..0x10) and 17 done pulses occur.
- Back-to-back: queue 0x55 and 0xAA -> exactly one clock of IDLE between the first stop bit's done pulse and the second start bit. Both frames are correct.
- Reset mid-frame: assert i_rst=0 during DATA bit 3 of 0xF0 with 2 bytes queued -> o_tx=1 next edge, o_empty=1, no done pulse, no further frames.
